seq_shifter: RTL

Multi-cycle iterative shift unit. It is the sequential counterpart to the team's combinational single-cycle 8-bit shifter. The unit accepts an operand and shift amount on a start handshake, shifts one bit position per clock, then presents the result with a one-cycle done pulse. It sits beside the ALU datapath for area-constrained builds and serves as a cycle-accurate cross-check model for the combinational shifter.

---
 rtl/seq_shifter_if.sv | 24 ++
 rtl/seq_shifter.sv | 91 +++++++++
 2 files changed

// File: rtl/seq_shifter_if.sv
// Request/result bundle for the iterative shifter: operand and control in, result and status out.
interface seq_shifter_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   shamt;
  logic             dir;
  logic             arith;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output start, in, shamt, dir, arith,
    input  out, busy, done
  );

  modport slave (
    input  start, in, shamt, dir, arith,
    output out, busy, done
  );
endinterface

// File: rtl/seq_shifter.sv
// Iterative shifter: moves the captured operand one bit per clock, then publishes it with a done pulse.
//
// state | meaning
// IDLE  | waiting for start; out holds the last result
// SHIFT | one bit per cycle while cnt != 0; on cnt == 0 the result is registered
// DONE  | done pulse for one cycle, then back to IDLE
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  seq_shifter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic             dir_q, dir_nxt;
  logic             arith_q, arith_nxt;
  logic [WIDTH-1:0] out_q, out_nxt;
  logic             fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      work    <= '0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state   <= state_nxt;
      work    <= work_nxt;
      cnt     <= cnt_nxt;
      dir_q   <= dir_nxt;
      arith_q <= arith_nxt;
      out_q   <= out_nxt;
    end
  end

  // Sign fill only applies to right shifts; left shifts always bring in zero.
  assign fill = arith_q & work[WIDTH-1];

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    arith_nxt = arith_q;
    out_nxt   = out_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          work_nxt  = bus.in;
          cnt_nxt   = bus.shamt;
          dir_nxt   = bus.dir;
          arith_nxt = bus.arith;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          if (dir_q) work_nxt = {work[WIDTH-2:0], 1'b0};
          else       work_nxt = {fill, work[WIDTH-1:1]};
          cnt_nxt = cnt - SHW'(1);
        end else begin
          out_nxt   = work;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.out  = out_q;
  assign bus.busy = (state == SHIFT) || (state == DONE);
  assign bus.done = (state == DONE);

endmodule
